// File: rtl/syscall_console_responder_if.sv
// rtl/syscall_console_responder_if.sv - syscall request and character stream bundle
//
// Purpose: groups the syscall request handshake (initiator -> responder) and the
// console character stream (responder -> sink) into one interface.
// Signals:
//   sys_valid/sys_v0/sys_a0 : request from the syscall stage
//   sys_ready               : responder accepts the request this cycle
//   out_valid/out_char      : character presented by the responder
//   out_ready               : sink accepts the character
// Modports: master = syscall stage plus console sink, slave = responder.
interface syscall_console_responder_if;
  logic        sys_valid;
  logic [31:0] sys_v0;
  logic [31:0] sys_a0;
  logic        sys_ready;
  logic        out_valid;
  logic [7:0]  out_char;
  logic        out_ready;

  modport master (
    output sys_valid, sys_v0, sys_a0, out_ready,
    input  sys_ready, out_valid, out_char
  );

  modport slave (
    input  sys_valid, sys_v0, sys_a0, out_ready,
    output sys_ready, out_valid, out_char
  );
endinterface

// File: rtl/syscall_console_responder.sv
// rtl/syscall_console_responder.sv - syscall responder: print_string, print_int, exit
//
// Purpose: accepts one syscall request at a time and services it, streaming ASCII
// characters out and reading NUL-terminated strings from word-wide data memory.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   bus (slave)  : request handshake and character stream
//   busy         : high whenever the FSM is not in IDLE
//   mem_rd_en    : one-cycle read strobe per word; mem_addr is word aligned
//   mem_rd_data  : big-endian read data, valid MEM_LAT cycles after mem_rd_en
//   done         : one-cycle pulse when a request completes
//   halted       : sticky, set by exit (v0=10), cleared only by reset
// Optional feature macro: SYSCALL_PRINT_CHAR_EN (v0=11 prints a0[7:0]).
module syscall_console_responder #(
  parameter int unsigned MAX_STR_LEN = 1024,
  parameter int unsigned MEM_LAT     = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  syscall_console_responder_if.slave    bus,
  output logic                          busy,
  output logic                          mem_rd_en,
  output logic [31:0]                   mem_addr,
  input  logic [31:0]                   mem_rd_data,
  output logic                          done,
  output logic                          halted
);

  typedef enum logic [3:0] {
    IDLE, STR_REQ, STR_WAIT, STR_EMIT, INT_SIGN, INT_DIGIT, INT_EMIT,
    CHAR_EMIT, HALT, DONE
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] a0_q, a0_d;
  logic [31:0] ptr_q, ptr_d;
  logic [31:0] word_q, word_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] cnt_q, cnt_d;
  logic [1:0]  wait_q, wait_d;
  logic [31:0] mag_q, mag_d;
  logic [3:0]  pow_q, pow_d;
  logic [3:0]  digit_q, digit_d;
  logic        started_q, started_d;
  logic        halted_q, halted_d;
  logic [7:0]  cur_byte;

  // pow index 0 selects 10^9, index 9 selects 10^0
  function automatic logic [31:0] pow10(input logic [3:0] i);
    case (i)
      4'd0:    pow10 = 32'd1000000000;
      4'd1:    pow10 = 32'd100000000;
      4'd2:    pow10 = 32'd10000000;
      4'd3:    pow10 = 32'd1000000;
      4'd4:    pow10 = 32'd100000;
      4'd5:    pow10 = 32'd10000;
      4'd6:    pow10 = 32'd1000;
      4'd7:    pow10 = 32'd100;
      4'd8:    pow10 = 32'd10;
      default: pow10 = 32'd1;
    endcase
  endfunction

  // big-endian: byte 0 of the word sits in [31:24]
  always_comb begin
    case (idx_q)
      2'd0:    cur_byte = word_q[31:24];
      2'd1:    cur_byte = word_q[23:16];
      2'd2:    cur_byte = word_q[15:8];
      default: cur_byte = word_q[7:0];
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      a0_q      <= '0;
      ptr_q     <= '0;
      word_q    <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      wait_q    <= '0;
      mag_q     <= '0;
      pow_q     <= '0;
      digit_q   <= '0;
      started_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      a0_q      <= a0_d;
      ptr_q     <= ptr_d;
      word_q    <= word_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      wait_q    <= wait_d;
      mag_q     <= mag_d;
      pow_q     <= pow_d;
      digit_q   <= digit_d;
      started_q <= started_d;
      halted_q  <= halted_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    a0_d          = a0_q;
    ptr_d         = ptr_q;
    word_d        = word_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    wait_d        = wait_q;
    mag_d         = mag_q;
    pow_d         = pow_q;
    digit_d       = digit_q;
    started_d     = started_q;
    halted_d      = halted_q;
    bus.sys_ready = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_char  = 8'h00;
    mem_rd_en     = 1'b0;
    mem_addr      = 32'h0;
    done          = 1'b0;

    case (state_q)
      IDLE: begin
        // gated by rst so every output reads 0 while reset is held
        bus.sys_ready = !halted_q && !rst;
        if (bus.sys_valid && bus.sys_ready) begin
          a0_d      = bus.sys_a0;
          ptr_d     = bus.sys_a0;
          cnt_d     = '0;
          pow_d     = '0;
          digit_d   = '0;
          started_d = 1'b0;
          case (bus.sys_v0)
            32'd4:   state_d = STR_REQ;
            32'd1:   state_d = INT_SIGN;
            32'd10:  state_d = HALT;
`ifdef SYSCALL_PRINT_CHAR_EN
            32'd11:  state_d = CHAR_EMIT;
`endif
            default: state_d = DONE;
          endcase
        end
      end
      STR_REQ: begin
        mem_rd_en = 1'b1;
        mem_addr  = {ptr_q[31:2], 2'b00};
        idx_d     = ptr_q[1:0];
        wait_d    = '0;
        state_d   = STR_WAIT;
      end
      STR_WAIT: begin
        if (wait_q == 2'(MEM_LAT - 1)) begin
          word_d  = mem_rd_data;
          state_d = STR_EMIT;
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end
      STR_EMIT: begin
        if (cur_byte == 8'h00) begin
          state_d = DONE;
        end else begin
          bus.out_valid = 1'b1;
          bus.out_char  = cur_byte;
          if (bus.out_ready) begin
            ptr_d = ptr_q + 32'd1;
            cnt_d = cnt_q + 32'd1;
            if (cnt_q + 32'd1 == MAX_STR_LEN) state_d = DONE;
            else if (idx_q == 2'd3)           state_d = STR_REQ;
            else                              idx_d   = idx_q + 2'd1;
          end
        end
      end
      INT_SIGN: begin
        if (a0_q[31]) begin
          bus.out_valid = 1'b1;
          bus.out_char  = 8'h2D;
          if (bus.out_ready) begin
            mag_d   = 32'd0 - a0_q;
            state_d = INT_DIGIT;
          end
        end else begin
          mag_d   = a0_q;
          state_d = INT_DIGIT;
        end
      end
      INT_DIGIT: begin
        if (mag_q >= pow10(pow_q)) begin
          mag_d   = mag_q - pow10(pow_q);
          digit_d = digit_q + 4'd1;
        end else begin
          state_d = INT_EMIT;
        end
      end
      INT_EMIT: begin
        if (digit_q == 4'd0 && !started_q && pow_q != 4'd9) begin
          pow_d   = pow_q + 4'd1;
          state_d = INT_DIGIT;
        end else begin
          bus.out_valid = 1'b1;
          bus.out_char  = 8'h30 + {4'd0, digit_q};
          if (bus.out_ready) begin
            started_d = 1'b1;
            digit_d   = '0;
            if (pow_q == 4'd9) begin
              state_d = DONE;
            end else begin
              pow_d   = pow_q + 4'd1;
              state_d = INT_DIGIT;
            end
          end
        end
      end
      CHAR_EMIT: begin
        bus.out_valid = 1'b1;
        bus.out_char  = a0_q[7:0];
        if (bus.out_ready) state_d = DONE;
      end
      HALT: begin
        halted_d = 1'b1;
        state_d  = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy   = (state_q != IDLE);
  assign halted = halted_q;

endmodule

// File: tb/tb_syscall_console_responder.sv
// tb/tb_syscall_console_responder.sv - scoreboard bench for syscall_console_responder
module tb_syscall_console_responder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        busy, mem_rd_en, done, halted;
  logic [31:0] mem_addr;
  logic [31:0] mem_rd_data = 32'h0;

  syscall_console_responder_if bus ();

  syscall_console_responder #(.MAX_STR_LEN(8), .MEM_LAT(1)) dut (
    .clk(clk), .rst(rst), .bus(bus), .busy(busy), .mem_rd_en(mem_rd_en),
    .mem_addr(mem_addr), .mem_rd_data(mem_rd_data), .done(done), .halted(halted)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_miss = 0;
  int done_cnt = 0;
  int ready_mode = 0;   // 0: ready high, 1: toggle each cycle, 2: ready low
  logic [7:0]  exp_q[$];
  logic [31:0] addr_q[$];
  logic [31:0] mem [logic [31:0]];
  logic        pend = 1'b0;
  logic [7:0]  pend_char = 8'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // memory model, one-cycle read latency
  initial forever begin
    @(posedge clk);
    if (mem_rd_en) mem_rd_data <= mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
  end

  // sink ready pattern
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1:       bus.out_ready = ~bus.out_ready;
        2:       bus.out_ready = 1'b0;
        default: bus.out_ready = 1'b1;
      endcase
    end
  end

  // monitor: pops scoreboard entries whenever the DUT presents output
  initial forever begin
    @(negedge clk);
    if (rst) begin
      pend = 1'b0;
    end else begin
      if (pend) chk("hold_stable", {23'd0, bus.out_valid, bus.out_char}, {23'd0, 1'b1, pend_char});
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_miss++;
          $display("FAIL extra_char: got %h expected none", bus.out_char);
        end else begin
          chk("char", {24'd0, bus.out_char}, {24'd0, exp_q.pop_front()});
        end
      end
      pend      = bus.out_valid && !bus.out_ready;
      pend_char = bus.out_char;
      if (mem_rd_en) begin
        if (addr_q.size() == 0) begin
          n_vec++; n_miss++;
          $display("FAIL extra_read: got %h expected none", mem_addr);
        end else begin
          chk("rd_addr", mem_addr, addr_q.pop_front());
        end
      end
      if (done) done_cnt++;
    end
  end

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endtask

  task automatic send(input logic [31:0] v0, input logic [31:0] a0);
    bit got = 0;
    @(posedge clk); #1;
    bus.sys_valid = 1'b1; bus.sys_v0 = v0; bus.sys_a0 = a0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (bus.sys_ready) got = 1;
    end
    if (!got) chk("sys_ready_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    bus.sys_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int start = done_cnt;
    for (int i = 0; i < 300 && done_cnt == start; i++) begin
      @(negedge clk); #1;
    end
    chk({name, "_done"}, done_cnt - start, 32'd1);
    repeat (3) @(negedge clk);
    #1;
    chk({name, "_chars_left"}, exp_q.size(), 32'd0);
    chk({name, "_reads_left"}, addr_q.size(), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.sys_valid = 1'b0; bus.sys_v0 = 32'h0; bus.sys_a0 = 32'h0;
    mem[32'h10010000] = 32'h48690A00;
    mem[32'h00001000] = 32'h41424344;
    mem[32'h00001004] = 32'h45000000;
    mem[32'h00002000] = 32'h41424344;
    mem[32'h00003000] = 32'h41424344;
    mem[32'h00003004] = 32'h45464748;
    mem[32'h00003008] = 32'h494A4B4C;
    mem[32'h0000300C] = 32'h00000000;

    // reset state
    #12;
    chk("rst_sys_ready", {31'd0, bus.sys_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("idle_sys_ready", {31'd0, bus.sys_ready}, 32'd1);

    // aligned string
    push_str("Hi\n"); addr_q.push_back(32'h10010000);
    send(32'd4, 32'h10010000);
    wait_done("str_aligned");

    // unaligned, crossing words, with backpressure
    ready_mode = 1;
    push_str("CDE"); addr_q.push_back(32'h1000); addr_q.push_back(32'h1004);
    send(32'd4, 32'h1002);
    wait_done("str_unaligned");

    // length limit of 8 characters
    push_str("ABCDEFGH"); addr_q.push_back(32'h3000); addr_q.push_back(32'h3004);
    send(32'd4, 32'h3000);
    wait_done("str_maxlen");
    ready_mode = 0;

    // integers
    push_str("0");           send(32'd1, 32'h00000000); wait_done("int_zero");
    push_str("-123");        send(32'd1, 32'hFFFFFF85); wait_done("int_neg123");
    ready_mode = 1;
    push_str("-2147483648"); send(32'd1, 32'h80000000); wait_done("int_min");
    ready_mode = 0;
    push_str("2147483647");  send(32'd1, 32'h7FFFFFFF); wait_done("int_max");
    push_str("1000000000");  send(32'd1, 32'd1000000000); wait_done("int_1e9");

    // unsupported and print-char
    send(32'd7, 32'h0); wait_done("unsupported");
`ifdef SYSCALL_PRINT_CHAR_EN
    exp_q.push_back(8'h5A);
`endif
    send(32'd11, 32'h5A); wait_done("print_char");

    // reset in the middle of a string
    ready_mode = 2;
    addr_q.push_back(32'h2000);
    send(32'd4, 32'h2000);
    for (int i = 0; i < 50 && !bus.out_valid; i++) @(negedge clk);
    chk("mid_str_valid", {31'd0, bus.out_valid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("mid_rst_out_char", {24'd0, bus.out_char}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_sys_ready", {31'd0, bus.sys_ready}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    ready_mode = 0;
    @(negedge clk);
    chk("post_rst_sys_ready", {31'd0, bus.sys_ready}, 32'd1);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    chk("post_rst_reads_left", addr_q.size(), 32'd0);

    // exit
    send(32'd10, 32'h0); wait_done("exit");
    chk("halted_set", {31'd0, halted}, 32'd1);
    bus.sys_valid = 1'b1; bus.sys_v0 = 32'd1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("halt_sys_ready", {31'd0, bus.sys_ready}, 32'd0);
      chk("halt_busy", {31'd0, busy}, 32'd0);
    end
    bus.sys_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    #1 chk("rst_clears_halted", {31'd0, halted}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_restores_ready", {31'd0, bus.sys_ready}, 32'd1);

    // back-to-back after reset
    push_str("7"); send(32'd1, 32'd7); wait_done("after_halt");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
